// File: rtl/string_serializer_arbiter.sv
// string_serializer_arbiter
//   Round-robin arbiter that picks one of NR requesters, captures its fixed-size
//   WS-byte string, and streams it out one character per handshake. A string
//   ends at its first 0x00 byte or after WS bytes. An empty string is accepted
//   but produces no characters.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   req_vld   : per-requester string valid
//   req_rdy   : per-requester accept strobe (one-hot or zero, combinational)
//   req_str   : per-requester string, [req][char][bit], char 0 sent first
//   out_vld   : output character valid
//   out_rdy   : downstream ready
//   out_chr   : current character
//   out_last  : current character is the last of its string
//   out_src   : requester index that owns the current string
//   busy      : a string is being sent
//   str_cnt   : completed non-empty strings, wraps at 2^16
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | arbitrating; a grant captures a string (SEND if non-empty)
// SEND  | streaming buffered characters, one per out_vld && out_rdy
module string_serializer_arbiter #(
  parameter int WS = 8,
  parameter int NR = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NR-1:0]                 req_vld,
  output logic [NR-1:0]                 req_rdy,
  input  logic [NR-1:0][0:WS-1][7:0]    req_str,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [7:0]                    out_chr,
  output logic                          out_last,
  output logic [$clog2(NR)-1:0]         out_src,
  output logic                          busy,
  output logic [15:0]                   str_cnt
);

  localparam int SW = $clog2(NR);
  localparam int IW = (WS > 1) ? $clog2(WS) : 1;
  localparam int LW = $clog2(WS + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                r_state;
  logic [SW-1:0]         r_ptr;
  logic [0:WS-1][7:0]    r_buf;
  logic [LW-1:0]         r_len;
  logic [IW-1:0]         r_idx;
  logic                  r_out_vld;
  logic [7:0]            r_out_chr;
  logic                  r_out_last;
  logic [SW-1:0]         r_out_src;
  logic [15:0]           r_str_cnt;

  logic                  w_found;
  logic [SW-1:0]         w_gnt;
  logic [LW-1:0]         w_len;
  logic                  w_grant;
  logic [SW-1:0]         w_ptr_nxt;
  logic [IW-1:0]         w_idx_nxt;

  // Search from r_ptr upward (mod NR); iterating the offset downward lets the
  // smallest offset with a valid request win.
  always_comb begin : p_search
    int c;
    w_found = 1'b0;
    w_gnt   = '0;
    c       = 0;
    for (int k = NR - 1; k >= 0; k--) begin
      c = int'(r_ptr) + k;
      if (c >= NR) c = c - NR;
      if (req_vld[c]) begin
        w_found = 1'b1;
        w_gnt   = SW'(c);
      end
    end
  end

  // Length of the candidate string: index of the first NUL, else WS.
  always_comb begin
    w_len = LW'(WS);
    for (int i = WS - 1; i >= 0; i--) begin
      if (req_str[w_gnt][i] == 8'h00) w_len = LW'(i);
    end
  end

  // rst_n gates the strobe so it drops immediately, without waiting for a clock.
  assign w_grant   = rst_n && (r_state == S_IDLE) && w_found;
  assign req_rdy   = w_grant ? (NR'(1) << w_gnt) : '0;
  assign w_ptr_nxt = (w_gnt == SW'(NR - 1)) ? '0 : w_gnt + 1'b1;
  assign w_idx_nxt = r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_buf      <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_out_vld  <= 1'b0;
      r_out_chr  <= 8'h00;
      r_out_last <= 1'b0;
      r_out_src  <= '0;
      r_str_cnt  <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_buf     <= req_str[w_gnt];
            r_len     <= w_len;
            r_out_src <= w_gnt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= '0;
            // An empty string is consumed here and never reaches SEND.
            if (w_len != '0) begin
              r_state    <= S_SEND;
              r_out_vld  <= 1'b1;
              r_out_chr  <= req_str[w_gnt][0];
              r_out_last <= (w_len == LW'(1));
            end
          end
        end
        S_SEND: begin
          if (r_out_rdy_hs(r_out_vld, out_rdy)) begin
            if (r_out_last) begin
              r_state    <= S_IDLE;
              r_out_vld  <= 1'b0;
              r_out_last <= 1'b0;
              r_str_cnt  <= r_str_cnt + 16'd1;
            end else begin
              r_idx      <= w_idx_nxt;
              r_out_chr  <= r_buf[w_idx_nxt];
              r_out_last <= ((LW'(r_idx) + LW'(2)) == r_len);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  function automatic logic r_out_rdy_hs(input logic vld, input logic rdy);
    return vld && rdy;
  endfunction

  assign out_vld  = r_out_vld;
  assign out_chr  = r_out_chr;
  assign out_last = r_out_last;
  assign out_src  = r_out_src;
  assign busy     = (r_state == S_SEND);
  assign str_cnt  = r_str_cnt;

endmodule

// File: tb/tb_string_serializer_arbiter.sv
module tb_string_serializer_arbiter;

  logic                   clk;
  logic                   rst_n;
  logic [3:0]             req_vld;
  logic [3:0]             req_rdy;
  logic [3:0][0:7][7:0]   req_str;
  logic                   out_vld;
  logic                   out_rdy;
  logic [7:0]             out_chr;
  logic                   out_last;
  logic [1:0]             out_src;
  logic                   busy;
  logic [15:0]            str_cnt;

  string_serializer_arbiter #(.WS(8), .NR(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_str  (req_str),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_chr  (out_chr),
    .out_last (out_last),
    .out_src  (out_src),
    .busy     (busy),
    .str_cnt  (str_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        ordy;
    logic        scr;
    logic [3:0]  erdy;
    logic        evld;
    logic [7:0]  echr;
    logic        elast;
    logic [1:0]  esrc;
    logic        ebusy;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tv[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [63:0] s_janez;
  logic [7:0]  jz [8];

  function automatic vec_t mk(input logic rst, input logic [3:0] vld, input logic ordy,
                              input logic scr, input logic [3:0] erdy, input logic evld,
                              input logic [7:0] echr, input logic elast, input logic [1:0] esrc,
                              input logic ebusy, input logic [15:0] ecnt);
    vec_t v;
    v.rst = rst; v.vld = vld; v.ordy = ordy; v.scr = scr; v.erdy = erdy;
    v.evld = evld; v.echr = echr; v.elast = elast; v.esrc = esrc;
    v.ebusy = ebusy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  initial begin
    s_janez = "Janez No";
    jz = '{8'h4A, 8'h61, 8'h6E, 8'h65, 8'h7A, 8'h20, 8'h4E, 8'h6F};
    rst_n   = 1'b0;
    req_vld = 4'b0000;
    out_rdy = 1'b1;
    req_str[0] = s_janez;
    req_str[1] = {8'h00, "xyzabcd"};
    req_str[2] = {"Hi", 48'h0};
    req_str[3] = {"ABC", 40'h0};

    //             rst vld     ordy scr erdy   evld chr    last src busy cnt
    tv.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 16'd0));
    tv.push_back(mk(0, 4'b0001, 1, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 16'd0));
    tv.push_back(mk(1, 4'b0001, 1, 0, 4'b0001, 0, 8'h00, 0, 0, 0, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h4A, 0, 0, 1, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h61, 0, 0, 1, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h6E, 0, 0, 1, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h65, 0, 0, 1, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h7A, 0, 0, 1, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h20, 0, 0, 1, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h4E, 0, 0, 1, 16'd0));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h6F, 1, 0, 1, 16'd0));
    // "Hi": ptr=1 so req 2 wins
    tv.push_back(mk(1, 4'b0100, 1, 0, 4'b0100, 0, 8'h6F, 0, 0, 0, 16'd1));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h48, 0, 2, 1, 16'd1));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h69, 1, 2, 1, 16'd1));
    // ptr=3: req 3 beats reqs 0,1
    tv.push_back(mk(1, 4'b1011, 1, 0, 4'b1000, 0, 8'h69, 0, 2, 0, 16'd2));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h41, 0, 3, 1, 16'd2));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h42, 0, 3, 1, 16'd2));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 1, 8'h43, 1, 3, 1, 16'd2));
    // empty string from req 1: grant only, ptr becomes 2
    tv.push_back(mk(1, 4'b0010, 1, 0, 4'b0010, 0, 8'h43, 0, 3, 0, 16'd3));
    tv.push_back(mk(1, 4'b0011, 1, 0, 4'b0001, 0, 8'h43, 0, 1, 0, 16'd3));
    // Janez again with a 3-cycle stall at idx 3, source string scrambled after capture
    tv.push_back(mk(1, 4'b0000, 1, 1, 4'b0000, 1, 8'h4A, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 1, 1, 4'b0000, 1, 8'h61, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 1, 1, 4'b0000, 1, 8'h6E, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 0, 1, 4'b0000, 1, 8'h65, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 0, 1, 4'b0000, 1, 8'h65, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 0, 1, 4'b0000, 1, 8'h65, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 1, 1, 4'b0000, 1, 8'h65, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 1, 1, 4'b0000, 1, 8'h7A, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 1, 1, 4'b0000, 1, 8'h20, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 1, 1, 4'b0000, 1, 8'h4E, 0, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0001, 1, 1, 4'b0000, 1, 8'h6F, 1, 0, 1, 16'd3));
    tv.push_back(mk(1, 4'b0000, 1, 0, 4'b0000, 0, 8'h6F, 0, 0, 0, 16'd4));

    foreach (tv[i]) begin
      @(posedge clk); #1;
      rst_n      = tv[i].rst;
      req_vld    = tv[i].vld;
      out_rdy    = tv[i].ordy;
      req_str[0] = tv[i].scr ? {8{8'h5A}} : s_janez;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {31'h0, req_rdy, out_vld, out_chr, out_last, out_src, busy, str_cnt},
          {31'h0, tv[i].erdy, tv[i].evld, tv[i].echr, tv[i].elast, tv[i].esrc,
           tv[i].ebusy, tv[i].ecnt});
    end

    // Round robin with all requesters valid from reset release, 1-char strings.
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] b;
      b = 8'h61 + 8'(k);
      req_str[k] = {b, 56'h0};
    end
    req_vld = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      logic [3:0] erdy;
      logic [1:0] s;
      s = 2'((c / 2) % 4);
      erdy = (c % 2 == 0) ? (4'b0001 << s) : 4'b0000;
      @(negedge clk);
      if (c % 2 == 0)
        chk($sformatf("rr_grant%0d", c), {59'h0, req_rdy, out_vld}, {59'h0, erdy, 1'b0});
      else
        chk($sformatf("rr_send%0d", c), {48'h0, req_rdy, out_vld, out_chr, out_last, out_src},
            {48'h0, 4'b0000, 1'b1, 8'h61 + 8'(s), 1'b1, s});
      @(posedge clk); #1;
    end
    req_vld = 4'b0000;
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Reset mid-string: ptr is 1 here, so req 3 would win without the reset.
    req_str[0] = s_janez;
    req_str[3] = {"ABC", 40'h0};
    req_vld = 4'b0001;
    @(negedge clk);
    chk("rst_pre_grant", {60'h0, req_rdy}, {60'h0, 4'b0001});
    @(posedge clk); #1;
    req_vld = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst_chr%0d", i), {44'h0, req_rdy, out_vld, out_chr, str_cnt},
          {44'h0, 4'b0000, 1'b1, jz[i], 16'd5});
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {37'h0, req_rdy, out_vld, out_last, busy, out_chr, out_src, str_cnt},
        {37'h0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 16'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_regrant", {60'h0, req_rdy}, {60'h0, 4'b0001});
    @(posedge clk); #1;
    req_vld = 4'b0000;
    @(negedge clk);
    chk("rst_first_chr", {53'h0, out_vld, out_chr, out_src}, {53'h0, 1'b1, 8'h4A, 2'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
